seq_div: RTL

Sequential radix-2 restoring divider, the inverse companion to the team's 16x16 Wallace-tree multiplier.
- Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor, producing a 2*WIDTH-bit quotient and a WIDTH-bit remainder.
- Unsigned or two's-complement signed, selected by alufn.
- Sits beside the multiplier in the ALU datapath and uses a start/busy/done handshake.

---
 rtl/seq_div.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seq_div.sv
// Sequential radix-2 restoring divider: 2*WIDTH-bit dividend by a WIDTH-bit divisor,
// unsigned or two's-complement signed, with a start/busy/done handshake.
module seq_div #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               alufn,
  input  logic [2*WIDTH-1:0] A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Q,
  output logic [WIDTH-1:0]   R,
  output logic               busy,
  output logic               done,
  output logic               div_zero
);

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(DW) + 1;
  localparam int unsigned LAST  = DW - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q;
  logic [DW-1:0]     dvd_q;
  logic [WIDTH-1:0]  dmag_q;
  logic [WIDTH:0]    prem_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              qneg_q;
  logic              rneg_q;
  logic [DW-1:0]     q_q;
  logic [WIDTH-1:0]  r_q;
  logic              busy_q;
  logic              done_q;
  logic              dz_q;

  logic              a_neg;
  logic              b_neg;
  logic [DW-1:0]     a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic [WIDTH+1:0]  shift_v;
  logic [WIDTH+1:0]  diff_v;
  logic              qbit;

  // Operand magnitudes; sign handling only applies in signed mode
  assign a_neg = alufn & A[DW-1];
  assign b_neg = alufn & B[WIDTH-1];
  assign a_mag = a_neg ? DW'(-A) : A;
  assign b_mag = b_neg ? WIDTH'(-B) : B;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor
  always_comb begin
    shift_v = {prem_q, dvd_q[DW-1]};
    diff_v  = shift_v - {2'b00, dmag_q};
    qbit    = ~diff_v[WIDTH+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dmag_q  <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            dz_q   <= 1'b0;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            dvd_q  <= a_mag;
            dmag_q <= b_mag;
            prem_q <= '0;
            cnt_q  <= '0;
            // Divide-by-zero skips the iterations and reports a fixed result
            if (B == '0) begin
              q_q     <= '1;
              r_q     <= A[WIDTH-1:0];
              dz_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          prem_q <= qbit ? diff_v[WIDTH:0] : shift_v[WIDTH:0];
          dvd_q  <= {dvd_q[DW-2:0], qbit};
          if (cnt_q == CNT_W'(LAST)) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        FIX: begin
          q_q     <= qneg_q ? DW'(-dvd_q) : dvd_q;
          r_q     <= rneg_q ? WIDTH'(-prem_q[WIDTH-1:0]) : prem_q[WIDTH-1:0];
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Q        = q_q;
  assign R        = r_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule
